// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: once-per-frame game sequencer for the Flappy VGA demo.
// Bird physics, pipe scroll, hole randomisation, collision check and score.
module flappy_game_ctrl #(
    parameter int GRAVITY     = 1,
    parameter int FLAP_VEL    = 12,
    parameter int MAX_FALL    = 10,
    parameter int PIPE_SPEED  = 2,
    parameter int DEAD_FRAMES = 60
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       flap_btn,
    output logic [8:0] bird_pos,
    output logic [8:0] hole_pos,
    output logic [9:0] pipe_pos,
    output logic [7:0] score,
    output logic       playing,
    output logic       game_over
);
    localparam int CW = $clog2(DEAD_FRAMES + 1);
    localparam logic [8:0] BIRD_RST = 9'd240;
    localparam logic [8:0] HOLE_RST = 9'd165;
    localparam logic [9:0] PIPE_RST = 10'd740;
    localparam logic [9:0] PIPE_STEP = 10'(PIPE_SPEED);
    localparam logic [CW-1:0] DEAD_MAX = CW'(DEAD_FRAMES);
    localparam logic signed [6:0] GRAV_S = 7'(GRAVITY);
    localparam logic signed [6:0] MAXF_S = 7'(MAX_FALL);
    localparam logic signed [5:0] FLAP_S = -6'(FLAP_VEL);

    typedef enum logic [2:0] {
        IDLE, PLAY_WAIT, UPD_BIRD, UPD_PIPE, CHECK, DEAD
    } state_e;

    state_e state_q, state_d;
    logic [1:0] sync_q, sync_d;
    logic prev_q, prev_d;
    logic edge_q, edge_d;
    logic pend_q, pend_d;
    logic hit_q, hit_d;
    logic playing_q, playing_d;
    logic over_q, over_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] score_q, score_d;
    logic [8:0] bird_q, bird_d;
    logic [8:0] hole_q, hole_d;
    logic [9:0] pipe_q, pipe_d;
    logic signed [5:0] vel_q, vel_d;
    logic [CW-1:0] dcnt_q, dcnt_d;

    logic signed [6:0] vel_inc;
    logic signed [5:0] vel_new;
    logic signed [10:0] nb;
    logic [9:0] pipe_next, bird_w, hole_w;
    logic wrap, overlap, clear;

    always_comb begin
        sync_d = {sync_q[0], flap_btn};
        prev_d = sync_q[1];
        edge_d = sync_q[1] & ~prev_q;
        lfsr_d = lfsr_q;
        if (frame_tick) begin
            lfsr_d = {lfsr_q[6:0],
                      lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_comb begin
        vel_inc = 7'(vel_q) + GRAV_S;
        if (pend_q) begin
            vel_new = FLAP_S;
        end else if (vel_inc > MAXF_S) begin
            vel_new = MAXF_S[5:0];
        end else begin
            vel_new = vel_inc[5:0];
        end
        // 11-bit signed so a strong flap near the top cannot wrap
        nb = signed'({2'b00, bird_q}) + 11'(vel_new);
        wrap = pipe_q <= PIPE_STEP;
        pipe_next = wrap ? PIPE_RST : pipe_q - PIPE_STEP;
        bird_w = {1'b0, bird_q};
        hole_w = {1'b0, hole_q};
        overlap = (pipe_q >= 10'd52) && (pipe_q <= 10'd199);
        clear = (bird_w >= hole_w + 10'd50) && (bird_w <= hole_w + 10'd151);
    end

    always_comb begin
        state_d = state_q;
        bird_d = bird_q;
        hole_d = hole_q;
        pipe_d = pipe_q;
        score_d = score_q;
        vel_d = vel_q;
        hit_d = hit_q;
        dcnt_d = dcnt_q;
        pend_d = pend_q | edge_q;
        unique case (state_q)
            IDLE: begin
                bird_d = BIRD_RST;
                hole_d = HOLE_RST;
                pipe_d = PIPE_RST;
                score_d = 8'd0;
                vel_d = 6'sd0;
                hit_d = 1'b0;
                pend_d = edge_q;
                if (edge_q) state_d = PLAY_WAIT;
            end
            PLAY_WAIT: begin
                if (frame_tick) state_d = UPD_BIRD;
            end
            UPD_BIRD: begin
                pend_d = edge_q;
                vel_d = vel_new;
                if (nb < 11'sd50) begin
                    bird_d = 9'd50;
                    vel_d = 6'sd0;
                end else if (nb >= 11'sd479) begin
                    bird_d = 9'd479;
                    hit_d = 1'b1;
                end else begin
                    bird_d = nb[8:0];
                end
                state_d = UPD_PIPE;
            end
            UPD_PIPE: begin
                pipe_d = pipe_next;
                if (wrap) hole_d = 9'd40 + {1'b0, lfsr_q};
                if (pipe_q >= 10'd51 && pipe_next < 10'd51 &&
                    score_q != 8'hFF) begin
                    score_d = score_q + 8'd1;
                end
                state_d = CHECK;
            end
            CHECK: begin
                if (hit_q || (overlap && !clear)) begin
                    state_d = DEAD;
                    dcnt_d = '0;
                end else begin
                    state_d = PLAY_WAIT;
                end
            end
            DEAD: begin
                pend_d = 1'b0;
                if (frame_tick && dcnt_q < DEAD_MAX) dcnt_d = dcnt_q + 1'b1;
                if (edge_q && dcnt_q >= DEAD_MAX) begin
                    state_d = IDLE;
                    bird_d = BIRD_RST;
                    hole_d = HOLE_RST;
                    pipe_d = PIPE_RST;
                    score_d = 8'd0;
                    vel_d = 6'sd0;
                    hit_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        playing_d = (state_d == PLAY_WAIT) || (state_d == UPD_BIRD) ||
                    (state_d == UPD_PIPE) || (state_d == CHECK);
        over_d = state_d == DEAD;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sync_q <= 2'b00;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
            pend_q <= 1'b0;
            hit_q <= 1'b0;
            playing_q <= 1'b0;
            over_q <= 1'b0;
            lfsr_q <= 8'hA5;
            score_q <= 8'd0;
            bird_q <= BIRD_RST;
            hole_q <= HOLE_RST;
            pipe_q <= PIPE_RST;
            vel_q <= 6'sd0;
            dcnt_q <= '0;
        end else begin
            state_q <= state_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            edge_q <= edge_d;
            pend_q <= pend_d;
            hit_q <= hit_d;
            playing_q <= playing_d;
            over_q <= over_d;
            lfsr_q <= lfsr_d;
            score_q <= score_d;
            bird_q <= bird_d;
            hole_q <= hole_d;
            pipe_q <= pipe_d;
            vel_q <= vel_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign bird_pos = bird_q;
    assign hole_pos = hole_q;
    assign pipe_pos = pipe_q;
    assign score = score_q;
    assign playing = playing_q;
    assign game_over = over_q;
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl: frame-level scoreboard bench for flappy_game_ctrl.
// A reference game model predicts outputs; tables pin the hand-derived cases.
module tb_flappy_game_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic frame_tick = 1'b0;
    logic flap_btn = 1'b0;
    logic [8:0] bird_pos, hole_pos;
    logic [9:0] pipe_pos;
    logic [7:0] score;
    logic playing, game_over;

    flappy_game_ctrl dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick),
        .flap_btn(flap_btn), .bird_pos(bird_pos), .hole_pos(hole_pos),
        .pipe_pos(pipe_pos), .score(score), .playing(playing),
        .game_over(game_over)
    );

    always #5 clock = ~clock;

    typedef struct {
        int bird; int hole; int pipe; int score; int playing; int over;
    } exp_t;
    typedef struct { int kind; int bird; int pipe; } vec_t;

    exp_t sb[$];
    vec_t ff[13];
    vec_t cl[4];
    int ff_bird[13] = '{228, 217, 207, 198, 190, 183, 177, 172, 168,
                        165, 163, 162, 162};
    int n_assert = 0;
    int n_fail = 0;
    int smp_bird[4], smp_pipe[4], smp_go[4];

    // reference model; m_st: 0 idle, 1 playing, 2 dead
    int m_bird, m_hole, m_pipe, m_score, m_vel, m_pend, m_hit;
    int m_cnt, m_lfsr, m_st;

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic m_game_reset();
        m_bird = 240; m_hole = 165; m_pipe = 740; m_score = 0;
        m_vel = 0; m_pend = 0; m_hit = 0; m_cnt = 0;
    endtask

    task automatic m_hard_reset();
        m_game_reset();
        m_lfsr = 8'hA5;
        m_st = 0;
    endtask

    task automatic m_edge();
        if (m_st == 0) begin
            m_st = 1; m_pend = 1;
        end else if (m_st == 1) begin
            m_pend = 1;
        end else if (m_cnt >= 60) begin
            m_game_reset();
            m_st = 0;
        end
    endtask

    task automatic m_tick(input int late);
        int fb, nb, old;
        fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        m_lfsr = ((m_lfsr << 1) & 255) | fb;
        if (m_st == 2) begin
            if (m_cnt < 60) m_cnt++;
        end else if (m_st == 1) begin
            if (m_pend != 0) m_vel = -12;
            else m_vel = (m_vel + 1 > 10) ? 10 : m_vel + 1;
            m_pend = late;
            nb = m_bird + m_vel;
            if (nb < 50) begin
                m_bird = 50; m_vel = 0;
            end else if (nb >= 479) begin
                m_bird = 479; m_hit = 1;
            end else begin
                m_bird = nb;
            end
            old = m_pipe;
            if (m_pipe <= 2) begin
                m_pipe = 740; m_hole = 40 + m_lfsr;
            end else begin
                m_pipe -= 2;
            end
            if (old >= 51 && m_pipe < 51 && m_score < 255) m_score++;
            if (m_hit != 0 || (m_pipe >= 52 && m_pipe <= 199 &&
                !(m_bird >= m_hole + 50 && m_bird <= m_hole + 151))) begin
                m_st = 2; m_cnt = 0;
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.bird = m_bird; e.hole = m_hole; e.pipe = m_pipe;
        e.score = m_score; e.playing = (m_st == 1); e.over = (m_st == 2);
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_sb: got empty queue, expected an entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_bird"}, bird_pos, e.bird);
            check({tag, "_hole"}, hole_pos, e.hole);
            check({tag, "_pipe"}, pipe_pos, e.pipe);
            check({tag, "_score"}, score, e.score);
            check({tag, "_playing"}, playing, e.playing);
            check({tag, "_over"}, game_over, e.over);
        end
    endtask

    task automatic press();
        @(negedge clock);
        flap_btn = 1'b1;
        repeat (2) @(negedge clock);
        flap_btn = 1'b0;
        repeat (5) @(negedge clock);
        m_edge();
    endtask

    // kind: 0 tick only, 1 flap well before tick, 2 flap edge with tick,
    // 3 flap edge during the bird update
    task automatic frame(input int kind);
        if (kind == 1) press();
        @(negedge clock);
        if (kind >= 2) begin
            flap_btn = 1'b1;
            repeat (2) @(negedge clock);
            flap_btn = 1'b0;
            if (kind == 2) @(negedge clock);
        end
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp_bird[i] = bird_pos;
            smp_pipe[i] = pipe_pos;
            smp_go[i] = game_over;
            @(negedge clock);
        end
        if (kind == 2) m_edge();
        m_tick(kind == 3 ? 1 : 0);
        push_exp();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_bird"}, bird_pos, 240);
        check({tag, "_hole"}, hole_pos, 165);
        check({tag, "_pipe"}, pipe_pos, 740);
        check({tag, "_score"}, score, 0);
        check({tag, "_playing"}, playing, 0);
        check({tag, "_over"}, game_over, 0);
    endtask

    initial begin
        int guard, kind, wraps;
        for (int i = 0; i < 13; i++) begin
            ff[i].kind = 0;
            ff[i].bird = ff_bird[i];
            ff[i].pipe = 738 - 2 * i;
        end
        cl[0] = '{kind: 2, bird: 50, pipe: 708};
        cl[1] = '{kind: 0, bird: 51, pipe: 706};
        cl[2] = '{kind: 3, bird: 53, pipe: 704};
        cl[3] = '{kind: 0, bird: 50, pipe: 702};

        m_hard_reset();
        repeat (3) @(negedge clock);
        check_reset_vals("rst");
        reset = 1'b1;
        repeat (5) begin
            frame(0);
            drain("idle");
        end

        press();
        push_exp();
        drain("start");
        for (int i = 0; i < 13; i++) begin
            frame(ff[i].kind);
            drain("fall");
            check("fall_tbl_bird", bird_pos, ff[i].bird);
            check("fall_tbl_pipe", pipe_pos, ff[i].pipe);
            if (i == 0) begin
                check("t1_bird_hold", smp_bird[0], 240);
                check("t1_bird_upd", smp_bird[1], 228);
                check("t1_pipe_hold", smp_pipe[1], 740);
                check("t1_pipe_upd", smp_pipe[2], 738);
            end
        end
        guard = 13;
        while (m_st == 1 && guard < 100) begin
            frame(0);
            drain("fall");
            guard++;
        end
        check("floor_tick_no", guard, 50);
        check("floor_bird", smp_bird[1], 479);
        check("floor_go_t2", smp_go[2], 0);
        check("floor_go_t3", smp_go[3], 1);

        repeat (10) begin
            frame(0);
            drain("dead");
        end
        press();
        push_exp();
        drain("dead_f10");
        check("dead_f10_over", game_over, 1);
        repeat (49) begin
            frame(0);
            drain("dead");
        end
        press();
        push_exp();
        drain("dead_f59");
        frame(0);
        drain("dead");
        press();
        push_exp();
        drain("restart");
        check_reset_vals("restart");

        press();
        guard = 0;
        wraps = 0;
        while (m_score < 2 && m_st == 1 && guard < 900) begin
            kind = (m_bird >= m_hole + 128) ? ((guard % 2 == 1) ? 2 : 1) : 0;
            frame(kind);
            drain("play");
            if (m_pipe == 740) begin
                wraps++;
                check("wrap_hole", hole_pos, 40 + m_lfsr);
            end
            guard++;
        end
        check("play_score", score, 2);
        check("play_alive", game_over, 0);
        check("play_wraps", wraps, 1);

        guard = 0;
        while (m_st == 1 && guard < 400) begin
            frame(2);
            drain("coll");
            guard++;
        end
        check("coll_pipe", pipe_pos, 198);
        check("coll_bird", bird_pos, 50);
        check("coll_over", game_over, 1);
        check("coll_score", score, 2);

        repeat (60) begin
            frame(0);
            drain("dead2");
        end
        press();
        push_exp();
        drain("restart2");

        press();
        frame(0);
        drain("ceil");
        repeat (14) begin
            frame(2);
            drain("ceil");
        end
        check("ceil_pre", bird_pos, 60);
        for (int i = 0; i < 4; i++) begin
            frame(cl[i].kind);
            drain("ceil");
            check("ceil_tbl_bird", bird_pos, cl[i].bird);
            check("ceil_tbl_pipe", pipe_pos, cl[i].pipe);
        end

        @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        repeat (2) @(negedge clock);
        check("midop_pipe_pre", pipe_pos, m_pipe - 2);
        reset = 1'b0;
        #1;
        check_reset_vals("midop");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        m_hard_reset();
        frame(0);
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
